dff_check_monitor: RTL and testbench

Synthesizable in-line checker that sits downstream of the 4-bit register under test. It taps the same stimulus word that drives the register's D input and the register's Q output. It rebuilds the expected Q stream through a delay pipeline and compares it every cycle. It keeps saturating match/mismatch counts and latches a sticky failure once a mismatch limit is reached, so the register can be checked on silicon or FPGA without a simulation scoreboard.

---
 rtl/dff_check_pkg.sv | 21 ++
 rtl/dff_check_delay.sv | 29 ++
 rtl/dff_check_monitor.sv | 148 ++++++++++++++
 tb/tb_dff_check_monitor.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_check_pkg.sv
// Shared types, default parameters and the saturating-increment helper for the
// dff_check_monitor slice.
package dff_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        CHECK  = 2'd2,
        FAIL   = 2'd3
    } state_e;

    localparam int unsigned DEF_WIDTH          = 4;
    localparam int unsigned DEF_LATENCY        = 1;
    localparam int unsigned DEF_CNT_W          = 16;
    localparam int unsigned DEF_MISMATCH_LIMIT = 5;

    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
        return (v >= max_v) ? max_v : v + 64'd1;
    endfunction

endpackage

// File: rtl/dff_check_delay.sv
// WIDTH x LATENCY shift pipeline with enable and synchronous clear; rebuilds the
// expected Q stream from the stimulus word.
module dff_check_delay
    import dff_check_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [LATENCY];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int unsigned i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else if (en_i) begin
            pipe_q[0] <= d_i;
            for (int unsigned i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/dff_check_monitor.sv
// In-line checker for a register under test: compares Q against a delayed copy of D.
// Optional first-mismatch capture ports are enabled with DFF_CHECK_CAPTURE_EN.
module dff_check_monitor
    import dff_check_pkg::*;
#(
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned LATENCY        = DEF_LATENCY,
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter int unsigned MISMATCH_LIMIT = DEF_MISMATCH_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             chk_en,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             checking,
    output logic             limit_hit,
    output logic [1:0]       state_o
`ifdef DFF_CHECK_CAPTURE_EN
    ,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_act,
    output logic             first_valid
`endif
);

    localparam int unsigned        WCNT_W    = $clog2(LATENCY + 1);
    localparam logic [WCNT_W-1:0]  WCNT_LAST = WCNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   LIMIT     = CNT_W'(MISMATCH_LIMIT);

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  match_q, match_d;
    logic [CNT_W-1:0]  mism_q, mism_d;
    logic              checking_q, limit_q;
    logic [CNT_W-1:0]  match_inc, mism_inc;
    logic [WIDTH-1:0]  exp_w;
    logic              pipe_en, mismatch, capture;

    assign pipe_en = (state_q == WARMUP) || (state_q == CHECK);

    dff_check_delay #(
        .WIDTH  (WIDTH),
        .LATENCY(LATENCY)
    ) u_delay (
        .clk  (clk),
        .clr_i(rst),
        .en_i (pipe_en),
        .d_i  (d_in),
        .q_o  (exp_w)
    );

    assign mismatch  = (q_in != exp_w);
    assign match_inc = CNT_W'(sat_inc(64'(match_q), 64'(CNT_MAX)));
    assign mism_inc  = CNT_W'(sat_inc(64'(mism_q), 64'(CNT_MAX)));

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        match_d = match_q;
        mism_d  = mism_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (chk_en) begin
                    state_d = WARMUP;
                    wcnt_d  = '0;
                end
            end
            WARMUP: begin
                wcnt_d = wcnt_q + 1'b1;
                if (!chk_en)                 state_d = IDLE;
                else if (wcnt_q == WCNT_LAST) state_d = CHECK;
            end
            CHECK: begin
                // A limiting mismatch is counted and fails even if chk_en drops on that edge.
                if (!mismatch) begin
                    if (chk_en) match_d = match_inc;
                    else        state_d = IDLE;
                end else if (mism_inc == LIMIT) begin
                    mism_d  = mism_inc;
                    state_d = FAIL;
                    capture = 1'b1;
                end else if (!chk_en) begin
                    state_d = IDLE;
                end else begin
                    mism_d  = mism_inc;
                    capture = 1'b1;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            match_q    <= '0;
            mism_q     <= '0;
            checking_q <= 1'b0;
            limit_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            match_q    <= match_d;
            mism_q     <= mism_d;
            checking_q <= (state_d == CHECK);
            limit_q    <= (state_d == FAIL);
        end
    end

    assign match_cnt    = match_q;
    assign mismatch_cnt = mism_q;
    assign checking     = checking_q;
    assign limit_hit    = limit_q;
    assign state_o      = state_q;

`ifdef DFF_CHECK_CAPTURE_EN
    logic [WIDTH-1:0] first_exp_q, first_act_q;
    logic             first_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            first_exp_q   <= '0;
            first_act_q   <= '0;
            first_valid_q <= 1'b0;
        end else if (capture && !first_valid_q) begin
            first_exp_q   <= exp_w;
            first_act_q   <= q_in;
            first_valid_q <= 1'b1;
        end
    end

    assign first_exp   = first_exp_q;
    assign first_act   = first_act_q;
    assign first_valid = first_valid_q;
`endif

endmodule

// File: tb/tb_dff_check_monitor.sv
// Directed bench for dff_check_monitor: three instances (LATENCY=1, LATENCY=3, CNT_W=3)
// driven together, checked each cycle against a behavioural model via a scoreboard queue.
module tb_dff_check_monitor;

    typedef struct packed {
        logic [1:0]       st;
        int unsigned      w;
        int unsigned      m;
        int unsigned      mm;
        logic [7:0][3:0]  pipe;
        logic [3:0]       fe;
        logic [3:0]       fa;
        logic             fv;
    } ms_t;

    typedef struct packed {
        ms_t a;
        ms_t b;
        ms_t c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        chk_en = 1'b0;
    logic [3:0]  d_in = '0;
    logic [3:0]  q_a = '0, q_b = '0, q_c = '0;
    logic [15:0] match_a, mism_a, match_b, mism_b;
    logic [2:0]  match_c, mism_c;
    logic        ck_a, ck_b, ck_c, lh_a, lh_b, lh_c;
    logic [1:0]  st_a, st_b, st_c;
`ifdef DFF_CHECK_CAPTURE_EN
    logic [3:0]  fe_a, fa_a, fe_b, fa_b, fe_c, fa_c;
    logic        fv_a, fv_b, fv_c;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;
    ms_t         ma = '0, mb = '0, mc = '0;
    exp_t        sb[$];
    logic [3:0]  hist [4];
    int unsigned mode_a = 0, mode_b = 0, mode_c = 0;

    always #5 clk = ~clk;

    dff_check_monitor #(.WIDTH(4), .LATENCY(1), .CNT_W(16), .MISMATCH_LIMIT(5)) dut_a (
        .clk(clk), .rst(rst), .d_in(d_in), .q_in(q_a), .chk_en(chk_en),
        .match_cnt(match_a), .mismatch_cnt(mism_a), .checking(ck_a),
        .limit_hit(lh_a), .state_o(st_a)
`ifdef DFF_CHECK_CAPTURE_EN
        , .first_exp(fe_a), .first_act(fa_a), .first_valid(fv_a)
`endif
    );

    dff_check_monitor #(.WIDTH(4), .LATENCY(3), .CNT_W(16), .MISMATCH_LIMIT(5)) dut_b (
        .clk(clk), .rst(rst), .d_in(d_in), .q_in(q_b), .chk_en(chk_en),
        .match_cnt(match_b), .mismatch_cnt(mism_b), .checking(ck_b),
        .limit_hit(lh_b), .state_o(st_b)
`ifdef DFF_CHECK_CAPTURE_EN
        , .first_exp(fe_b), .first_act(fa_b), .first_valid(fv_b)
`endif
    );

    dff_check_monitor #(.WIDTH(4), .LATENCY(1), .CNT_W(3), .MISMATCH_LIMIT(5)) dut_c (
        .clk(clk), .rst(rst), .d_in(d_in), .q_in(q_c), .chk_en(chk_en),
        .match_cnt(match_c), .mismatch_cnt(mism_c), .checking(ck_c),
        .limit_hit(lh_c), .state_o(st_c)
`ifdef DFF_CHECK_CAPTURE_EN
        , .first_exp(fe_c), .first_act(fa_c), .first_valid(fv_c)
`endif
    );

    function automatic ms_t mstep(ms_t s, logic [3:0] d, logic [3:0] q, logic en, logic r,
                                  int unsigned lat, int unsigned lim, int unsigned mx);
        ms_t         n;
        logic [3:0]  e;
        int unsigned mm1;
        n = s;
        if (r) begin
            n = '0;
            return n;
        end
        e = s.pipe[lat-1];
        if (s.st == 2'd1 || s.st == 2'd2) n.pipe = {s.pipe[6:0], d};
        case (s.st)
            2'd0: if (en) begin n.st = 2'd1; n.w = 0; end
            2'd1: begin
                n.w = s.w + 1;
                if (!en) n.st = 2'd0;
                else if (s.w == lat - 1) n.st = 2'd2;
            end
            2'd2: begin
                if (q == e) begin
                    if (en) n.m = (s.m >= mx) ? mx : s.m + 1;
                    else    n.st = 2'd0;
                end else begin
                    mm1 = (s.mm >= mx) ? mx : s.mm + 1;
                    if (mm1 == lim || en) begin
                        n.mm = mm1;
                        if (mm1 == lim) n.st = 2'd3;
                        if (!s.fv) begin n.fe = e; n.fa = q; n.fv = 1'b1; end
                    end else begin
                        n.st = 2'd0;
                    end
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] qsel(int unsigned mode, int unsigned lat);
        if (mode == 1) return 4'hA;
        if (mode == 2) return hist[1];
        return hist[lat];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic cmp(input string p, input ms_t e, input logic [1:0] st, input logic [31:0] m,
                       input logic [31:0] mm, input logic ck, input logic lh);
        chk({p, "_state"},    32'(st), 32'(e.st));
        chk({p, "_match"},    m,       e.m);
        chk({p, "_mismatch"}, mm,      e.mm);
        chk({p, "_checking"}, 32'(ck), 32'(e.st == 2'd2));
        chk({p, "_limit"},    32'(lh), 32'(e.st == 2'd3));
    endtask

    task automatic step(input logic [3:0] d, input logic en, input logic r);
        exp_t e, g;
        d_in   = d;
        chk_en = en;
        rst    = r;
        q_a    = qsel(mode_a, 1);
        q_b    = qsel(mode_b, 3);
        q_c    = qsel(mode_c, 1);
        ma = mstep(ma, d, q_a, en, r, 1, 5, 65535);
        mb = mstep(mb, d, q_b, en, r, 3, 5, 65535);
        mc = mstep(mc, d, q_c, en, r, 1, 5, 7);
        e.a = ma; e.b = mb; e.c = mc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = d;
        g = sb.pop_front();
        cmp("a", g.a, st_a, 32'(match_a), 32'(mism_a), ck_a, lh_a);
        cmp("b", g.b, st_b, 32'(match_b), 32'(mism_b), ck_b, lh_b);
        cmp("c", g.c, st_c, 32'(match_c), 32'(mism_c), ck_c, lh_c);
`ifdef DFF_CHECK_CAPTURE_EN
        chk("a_first_exp", 32'(fe_a), 32'(g.a.fe));
        chk("a_first_act", 32'(fa_a), 32'(g.a.fa));
        chk("a_first_valid", 32'(fv_a), 32'(g.a.fv));
        chk("b_first_exp", 32'(fe_b), 32'(g.b.fe));
        chk("c_first_act", 32'(fa_c), 32'(g.c.fa));
`endif
    endtask

    initial begin
        for (int i = 0; i < 4; i++) hist[i] = '0;

        // reset, then idle with chk_en low
        step(4'h0, 1'b0, 1'b1);
        step(4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(4'($urandom_range(15)), 1'b0, 1'b0);
        chk("idle_state_a", 32'(st_a), 0);
        chk("idle_match_a", 32'(match_a), 0);

        // correct registers, 21 enabled edges
        for (int i = 0; i < 21; i++) begin
            step(4'($urandom_range(15)), 1'b1, 1'b0);
            if (i == 0) chk("a_warmup_entry", 32'(st_a), 1);
            if (i == 1) chk("a_check_entry", 32'(st_a), 2);
            if (i == 2) chk("b_still_warm", 32'(st_b), 1);
            if (i == 3) chk("b_check_entry", 32'(ck_b), 1);
        end
        chk("a_match19", 32'(match_a), 19);
        chk("a_mism0", 32'(mism_a), 0);
        chk("a_nolimit", 32'(lh_a), 0);
        chk("b_match17", 32'(match_b), 17);
        chk("b_mism0", 32'(mism_b), 0);
        chk("c_saturated", 32'(match_c), 7);
        step(4'h0, 1'b0, 1'b0);
        chk("a_back_idle", 32'(st_a), 0);

        // enable gap
        step(4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(4'($urandom_range(15)), 1'b1, 1'b0);
        chk("gap_match6", 32'(match_a), 6);
        for (int i = 0; i < 4; i++) step(4'($urandom_range(15)), 1'b0, 1'b0);
        chk("gap_hold6", 32'(match_a), 6);
        for (int i = 0; i < 5; i++) begin
            step(4'($urandom_range(15)), 1'b1, 1'b0);
            if (i == 0) chk("gap_rewarm", 32'(st_a), 1);
        end
        chk("gap_resume9", 32'(match_a), 9);

        // stuck Q on a/c, 1-stage register against the LATENCY=3 checker on b
        mode_a = 1; mode_b = 2; mode_c = 1;
        step(4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) step(4'(i), 1'b1, 1'b0);
        chk("stuck_mism5", 32'(mism_a), 5);
        chk("stuck_limit", 32'(lh_a), 1);
        chk("stuck_state3", 32'(st_a), 3);
        chk("stuck_match0", 32'(match_a), 0);
        chk("b_lat_limit", 32'(lh_b), 1);
        chk("b_lat_mism5", 32'(mism_b), 5);
`ifdef DFF_CHECK_CAPTURE_EN
        chk("cap_first_exp", 32'(fe_a), 1);
        chk("cap_first_act", 32'(fa_a), 32'hA);
        chk("cap_first_valid", 32'(fv_a), 1);
`endif

        // chk_en drops on the edge of the limiting mismatch
        step(4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(4'(i), 1'b1, 1'b0);
        step(4'h6, 1'b0, 1'b0);
        chk("simul_state3", 32'(st_a), 3);
        chk("simul_mism5", 32'(mism_a), 5);
        chk("b_drop_idle", 32'(st_b), 0);
        chk("b_drop_nocount", 32'(mism_b), 2);
        for (int i = 0; i < 2; i++) step(4'($urandom_range(15)), 1'b0, 1'b0);
        chk("fail_sticky", 32'(lh_a), 1);

        // reset mid-CHECK
        mode_a = 0; mode_b = 0; mode_c = 0;
        step(4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(4'($urandom_range(15)), 1'b1, 1'b0);
        step(4'($urandom_range(15)), 1'b1, 1'b1);
        chk("midrst_state", 32'(st_a), 0);
        chk("midrst_match", 32'(match_a), 0);
        chk("midrst_checking", 32'(ck_a), 0);
        for (int i = 0; i < 4; i++) step(4'($urandom_range(15)), 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
